// File: rtl/turbo_encode_stream.sv
// Block turbo encoder: buffers N bits, then streams N data symbols plus TAIL_BITS
// termination symbols from two 4-state RSC encoders. Define TURBO_ENC_PUNCTURE_EN for rate 1/2.
module turbo_encode_stream #(
  parameter int N         = 10,
  parameter int P         = 3,
  parameter int TAIL_BITS = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_bit,
  output logic out_valid,
  input  logic out_ready,
  output logic out_sys,
  output logic out_p1,
  output logic out_sys2,
  output logic out_p2,
  output logic out_p1_en,
  output logic out_p2_en,
  output logic out_last
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + TAIL_BITS);
  localparam logic [CW-1:0] LAST_LOAD = CW'(N - 1);
  localparam logic [CW-1:0] LAST_SYM  = CW'(N + TAIL_BITS - 1);
  localparam logic [IW:0]   N_EXT     = (IW + 1)'(N);
  localparam logic [IW:0]   P_EXT     = (IW + 1)'(P);
`ifdef TURBO_ENC_PUNCTURE_EN
  localparam logic PUNCT = 1'b1;
`else
  localparam logic PUNCT = 1'b0;
`endif

  typedef enum logic [1:0] {LOAD = 2'd0, DATA = 2'd1, TAIL = 2'd2} state_t;

  // One RSC step (feedback 7, feedforward 5): returns {parity, next s1, next s0}.
  function automatic logic [2:0] rsc_step(input logic u, input logic [1:0] s);
    logic a;
    a = u ^ s[1] ^ s[0];
    return {a ^ s[0], a, s[1]};
  endfunction

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next, cnt_inc;
  logic [IW-1:0] pi_idx, pi_next;
  logic [IW:0]   pi_sum, pi_adv;
  logic [N-1:0]  x_buf, x_next;
  logic [1:0]    s1, s1_next, s2, s2_next, base1, base2;
  logic [2:0]    step1, step2;
  logic          u1, u2, emit, clear_out, last_next, p1_en_next, p2_en_next;

  // Next-state, datapath and next-output computation.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pi_next    = pi_idx;
    x_next     = x_buf;
    s1_next    = s1;
    s2_next    = s2;
    u1         = 1'b0;
    u2         = 1'b0;
    base1      = s1;
    base2      = s2;
    emit       = 1'b0;
    clear_out  = 1'b0;
    last_next  = 1'b0;
    p1_en_next = 1'b1;
    p2_en_next = 1'b1;
    step1      = 3'b000;
    step2      = 3'b000;
    cnt_inc    = cnt + CW'(1);
    pi_sum     = {1'b0, pi_idx} + P_EXT;
    pi_adv     = (pi_sum >= N_EXT) ? (pi_sum - N_EXT) : pi_sum;

    case (state)
      LOAD: begin
        if (in_valid && in_ready) begin
          x_next[cnt[IW-1:0]] = in_bit;
          if (cnt == LAST_LOAD) begin
            // Symbol 0: both encoders start from 00 and pi(0) = 0.
            state_next = DATA;
            cnt_next   = '0;
            pi_next    = '0;
            u1         = x_buf[0];
            u2         = x_buf[0];
            base1      = 2'b00;
            base2      = 2'b00;
            emit       = 1'b1;
            p2_en_next = ~PUNCT;
          end else begin
            cnt_next = cnt_inc;
          end
        end else begin
          state_next = LOAD;
        end
      end
      DATA, TAIL: begin
        if (out_ready) begin
          if (cnt == LAST_SYM) begin
            state_next = LOAD;
            cnt_next   = '0;
            pi_next    = '0;
            s1_next    = 2'b00;
            s2_next    = 2'b00;
            clear_out  = 1'b1;
          end else begin
            cnt_next = cnt_inc;
            emit     = 1'b1;
            if (cnt_inc <= LAST_LOAD) begin
              state_next = DATA;
              pi_next    = pi_adv[IW-1:0];
              u1         = x_buf[cnt_inc[IW-1:0]];
              u2         = x_buf[pi_adv[IW-1:0]];
              p1_en_next = PUNCT ? ~cnt_inc[0] : 1'b1;
              p2_en_next = PUNCT ? cnt_inc[0] : 1'b1;
            end else begin
              // Termination input cancels the feedback so a = 0.
              state_next = TAIL;
              u1         = s1[1] ^ s1[0];
              u2         = s2[1] ^ s2[0];
              last_next  = (cnt_inc == LAST_SYM);
            end
          end
        end else begin
          state_next = state;
        end
      end
      default: begin
        state_next = LOAD;
        cnt_next   = '0;
        pi_next    = '0;
        s1_next    = 2'b00;
        s2_next    = 2'b00;
        clear_out  = 1'b1;
      end
    endcase

    if (emit) begin
      step1   = rsc_step(u1, base1);
      step2   = rsc_step(u2, base2);
      s1_next = step1[1:0];
      s2_next = step2[1:0];
    end else begin
      step1 = 3'b000;
      step2 = 3'b000;
    end
  end

  // State, buffer, encoder and registered output updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= LOAD;
      cnt       <= '0;
      pi_idx    <= '0;
      x_buf     <= '0;
      s1        <= 2'b00;
      s2        <= 2'b00;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sys   <= 1'b0;
      out_p1    <= 1'b0;
      out_sys2  <= 1'b0;
      out_p2    <= 1'b0;
      out_p1_en <= 1'b0;
      out_p2_en <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      pi_idx   <= pi_next;
      x_buf    <= x_next;
      s1       <= s1_next;
      s2       <= s2_next;
      in_ready <= (state_next == LOAD);
      if (emit) begin
        out_valid <= 1'b1;
        out_sys   <= u1;
        out_p1    <= step1[2];
        out_sys2  <= u2;
        out_p2    <= step2[2];
        out_p1_en <= p1_en_next;
        out_p2_en <= p2_en_next;
        out_last  <= last_next;
      end else if (clear_out) begin
        out_valid <= 1'b0;
        out_sys   <= 1'b0;
        out_p1    <= 1'b0;
        out_sys2  <= 1'b0;
        out_p2    <= 1'b0;
        out_p1_en <= 1'b0;
        out_p2_en <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

endmodule

// File: tb/tb_turbo_encode_stream.sv
// Directed self-checking bench for turbo_encode_stream (N=10, P=3, TAIL_BITS=2).
module tb_turbo_encode_stream;

  localparam int N    = 10;
  localparam int NSYM = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, out_sys, out_p1, out_sys2, out_p2;
  logic out_p1_en, out_p2_en, out_last;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Hand-computed vectors for block 1,1,1,0,0,0,1,1,1,0 (symbol 0 first).
  int blk_a[N]     = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
  int blk_z[N]     = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int a_sys[NSYM]  = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
  int a_p1[NSYM]   = '{1, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0};
  int a_sys2[NSYM] = '{1, 0, 1, 0, 1, 0, 1, 1, 0, 1, 1, 0};
  int a_p2[NSYM]   = '{1, 1, 0, 1, 1, 0, 1, 0, 0, 0, 1, 0};
  int z_all[NSYM]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  turbo_encode_stream #(.N(10), .P(3), .TAIL_BITS(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
    .out_valid(out_valid), .out_ready(out_ready), .out_sys(out_sys), .out_p1(out_p1),
    .out_sys2(out_sys2), .out_p2(out_p2), .out_p1_en(out_p1_en), .out_p2_en(out_p2_en),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; drives cnt bits, ends at the negedge after the last accept.
  task automatic send_block(input int bits[N], input int cnt, input logic hold);
    for (int i = 0; i < cnt; i++) begin
      in_valid = 1'b1;
      in_bit   = bits[i][0];
      check_val("in_ready_load", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
    end
    in_valid = hold;
  endtask

  // Called at the negedge after the Nth accept; collects NSYM symbols.
  task automatic recv_block(input string nm, input int e_sys[NSYM], input int e_p1[NSYM],
                            input int e_s2[NSYM], input int e_p2[NSYM], input logic stall);
    int idx = 0;
    int pc = 0;
    int budget = 0;
    logic p1e, p2e;
    check_val({nm, "_first_valid"}, {31'd0, out_valid}, 32'd1);
    while (idx < NSYM && budget < 200) begin
      budget++;
      if (out_valid) begin
`ifdef TURBO_ENC_PUNCTURE_EN
        p1e = (idx >= N) ? 1'b1 : (idx % 2 == 0);
        p2e = (idx >= N) ? 1'b1 : (idx % 2 == 1);
`else
        p1e = 1'b1;
        p2e = 1'b1;
`endif
        check_val($sformatf("%s_sys[%0d]", nm, idx), {31'd0, out_sys}, e_sys[idx]);
        check_val($sformatf("%s_p1[%0d]", nm, idx), {31'd0, out_p1}, e_p1[idx]);
        check_val($sformatf("%s_sys2[%0d]", nm, idx), {31'd0, out_sys2}, e_s2[idx]);
        check_val($sformatf("%s_p2[%0d]", nm, idx), {31'd0, out_p2}, e_p2[idx]);
        check_val($sformatf("%s_p1en[%0d]", nm, idx), {31'd0, out_p1_en}, {31'd0, p1e});
        check_val($sformatf("%s_p2en[%0d]", nm, idx), {31'd0, out_p2_en}, {31'd0, p2e});
        check_val($sformatf("%s_last[%0d]", nm, idx), {31'd0, out_last},
                  (idx == NSYM - 1) ? 32'd1 : 32'd0);
        check_val($sformatf("%s_in_ready[%0d]", nm, idx), {31'd0, in_ready}, 32'd0);
      end else begin
        check_val($sformatf("%s_gap_valid[%0d]", nm, idx), {31'd0, out_valid}, 32'd1);
      end
      out_ready = stall ? ((pc % 4 == 0) || (pc % 4 == 3)) : 1'b1;
      pc++;
      if (out_valid && out_ready) idx++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    check_val({nm, "_timeout"}, budget, (budget < 200) ? budget : 32'd0);
    check_val({nm, "_done_valid"}, {31'd0, out_valid}, 32'd0);
    check_val({nm, "_done_last"}, {31'd0, out_last}, 32'd0);
    check_val({nm, "_done_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_outs", {24'd0, out_sys, out_p1, out_sys2, out_p2, out_p1_en, out_p2_en,
                           out_last, 1'b0}, 32'd0);

    send_block(blk_a, N, 1'b0);
    recv_block("blkA", a_sys, a_p1, a_sys2, a_p2, 1'b0);

    send_block(blk_a, N, 1'b0);
    recv_block("stall", a_sys, a_p1, a_sys2, a_p2, 1'b1);

    send_block(blk_a, 5, 1'b0);
    reset = 1'b1;
    #1;
    check_val("midrst_valid", {31'd0, out_valid}, 32'd0);
    check_val("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_block(blk_z, N, 1'b0);
    recv_block("zero", z_all, z_all, z_all, z_all, 1'b0);

    send_block(blk_a, N, 1'b1);
    recv_block("b2b_1", a_sys, a_p1, a_sys2, a_p2, 1'b0);
    send_block(blk_a, N, 1'b0);
    recv_block("b2b_2", a_sys, a_p1, a_sys2, a_p2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
